// File: rtl/ram_mp.sv
// Flip-flop multi-port RAM: RPORT read / WPORT write ports, byte enables,
// read latency 0..2, optional same-cycle write forwarding and a clear
// sequencer that zeroes the array after reset or on init_req.
// Optional per-lane even parity storage and perr/pinj ports: `RAM_MP_PARITY_EN.
module ram_mp #(
  parameter  int DATA   = 32,
  parameter  int BYTE   = 8,
  parameter  int DEPTH  = 16,
  parameter  int RPORT  = 2,
  parameter  int WPORT  = 1,
  parameter  int RD_LAT = 1,
  parameter  int BYPASS = 1,
  localparam int ADDR   = $clog2(DEPTH),
  localparam int BE     = DATA / BYTE
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic                       init_req,
  output logic                       busy,
  input  logic [RPORT-1:0]           ren,
  input  logic [RPORT-1:0][ADDR-1:0] raddr,
  output logic [RPORT-1:0][DATA-1:0] rdata,
  output logic [RPORT-1:0]           rvalid,
`ifdef RAM_MP_PARITY_EN
  output logic [RPORT-1:0]           perr,
  input  logic [WPORT-1:0]           pinj,
`endif
  input  logic [WPORT-1:0]           wen,
  input  logic [WPORT-1:0][ADDR-1:0] waddr,
  input  logic [WPORT-1:0][DATA-1:0] wdata,
  input  logic [WPORT-1:0][BE-1:0]   wbe
);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_e;

  localparam logic [ADDR-1:0] LAST = ADDR'(DEPTH - 1);

  function automatic logic in_range(input logic [ADDR-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  state_e          state_q, state_d;
  logic [ADDR-1:0] clr_q, clr_d;
  logic            ready;

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_INIT;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // NOTE: defaults first, so no path through the case leaves a signal
  // unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    case (state_q)
      S_INIT: begin
        clr_d = clr_q + ADDR'(1);
        if (clr_q == LAST) begin
          state_d = S_READY;
          clr_d   = '0;
        end
      end
      S_READY: begin
        if (init_req) begin
          state_d = S_INIT;
          clr_d   = '0;
        end
      end
      default: begin
        state_d = S_INIT;
        clr_d   = '0;
      end
    endcase
  end

  assign ready = (state_q == S_READY);
  assign busy  = (state_q == S_INIT);

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  logic [WPORT-1:0] wr_ok;

  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < WPORT; j++) begin
      wr_ok[j] = ready && wen[j] && in_range(waddr[j]);
    end
  end

`ifdef RAM_MP_PARITY_EN
  logic [WPORT-1:0][BE-1:0] wr_par;

  // Even parity per lane; pinj flips the stored bit of every lane written.
  always_comb begin
    wr_par = '0;
    for (int j = 0; j < WPORT; j++) begin
      for (int k = 0; k < BE; k++) begin
        wr_par[j][k] = (^wdata[j][k*BYTE +: BYTE]) ^ pinj[j];
      end
    end
  end
`endif

  logic [DATA-1:0] mem [DEPTH];
`ifdef RAM_MP_PARITY_EN
  logic [BE-1:0]   par_mem [DEPTH];
`endif

  // NOTE: the array has no reset; the clear sequencer zeroes it one entry per
  // cycle, so the storage stays plain enable flops.
  // Later ports overwrite earlier ones in loop order, so the highest port
  // index wins per lane.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[clr_q] <= '0;
`ifdef RAM_MP_PARITY_EN
      par_mem[clr_q] <= '0;
`endif
    end else begin
      for (int j = 0; j < WPORT; j++) begin
        for (int k = 0; k < BE; k++) begin
          if (wr_ok[j] && wbe[j][k]) begin
            mem[waddr[j]][k*BYTE +: BYTE] <= wdata[j][k*BYTE +: BYTE];
`ifdef RAM_MP_PARITY_EN
            par_mem[waddr[j]][k] <= wr_par[j][k];
`endif
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: array lookup merged with same-cycle writes when BYPASS=1
  // ---------------------------------------------------------------------------
  logic [RPORT-1:0]           rd_fire;
  logic [RPORT-1:0][DATA-1:0] rd_word;
`ifdef RAM_MP_PARITY_EN
  logic [RPORT-1:0][BE-1:0]   rd_par;
  logic [RPORT-1:0]           rd_perr;
`endif

  // Out-of-range and idle reads leave the word (and parity) at zero.
  always_comb begin
    rd_fire = '0;
    rd_word = '0;
`ifdef RAM_MP_PARITY_EN
    rd_par  = '0;
    rd_perr = '0;
`endif
    for (int i = 0; i < RPORT; i++) begin
      rd_fire[i] = ready && ren[i];
      if (rd_fire[i] && in_range(raddr[i])) begin
        rd_word[i] = mem[raddr[i]];
`ifdef RAM_MP_PARITY_EN
        rd_par[i] = par_mem[raddr[i]];
`endif
        for (int j = 0; j < WPORT; j++) begin
          for (int k = 0; k < BE; k++) begin
            if ((BYPASS != 0) && wr_ok[j] && wbe[j][k] && (waddr[j] == raddr[i])) begin
              rd_word[i][k*BYTE +: BYTE] = wdata[j][k*BYTE +: BYTE];
`ifdef RAM_MP_PARITY_EN
              rd_par[i][k] = wr_par[j][k];
`endif
            end
          end
        end
      end
`ifdef RAM_MP_PARITY_EN
      for (int k = 0; k < BE; k++) begin
        rd_perr[i] = rd_perr[i] | ((^rd_word[i][k*BYTE +: BYTE]) ^ rd_par[i][k]);
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Read latency
  // ---------------------------------------------------------------------------
  if (RD_LAT == 0) begin : g_comb
    assign rvalid = rd_fire;
    assign rdata  = rd_word;
`ifdef RAM_MP_PARITY_EN
    assign perr   = rd_perr;
`endif
  end else begin : g_pipe
    logic [RPORT-1:0]           vld_q [RD_LAT];
    logic [RPORT-1:0][DATA-1:0] dat_q [RD_LAT];
`ifdef RAM_MP_PARITY_EN
    logic [RPORT-1:0]           err_q [RD_LAT];
`endif

    // Reset flushes in-flight reads; an init_req lets them drain normally.
    always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
        for (int s = 0; s < RD_LAT; s++) begin
          vld_q[s] <= '0;
          dat_q[s] <= '0;
`ifdef RAM_MP_PARITY_EN
          err_q[s] <= '0;
`endif
        end
      end else begin
        vld_q[0] <= rd_fire;
        dat_q[0] <= rd_word;
`ifdef RAM_MP_PARITY_EN
        err_q[0] <= rd_perr;
`endif
        for (int s = 1; s < RD_LAT; s++) begin
          vld_q[s] <= vld_q[s-1];
          dat_q[s] <= dat_q[s-1];
`ifdef RAM_MP_PARITY_EN
          err_q[s] <= err_q[s-1];
`endif
        end
      end
    end

    assign rvalid = vld_q[RD_LAT-1];
    assign rdata  = dat_q[RD_LAT-1];
`ifdef RAM_MP_PARITY_EN
    assign perr   = err_q[RD_LAT-1];
`endif
  end

endmodule
